// File: rtl/al_pkg.sv
// Shared constants and state encoding for the alarm sequencer.
package al_pkg;

    localparam int unsigned AL_HHMM_W = 16;
    localparam int unsigned AL_CNT_W  = 8;

    typedef logic [1:0] al_state_t;

    localparam al_state_t AL_IDLE   = 2'd0;
    localparam al_state_t AL_RING   = 2'd1;
    localparam al_state_t AL_SNOOZE = 2'd2;

endpackage

// File: rtl/al_min_counter.sv
// 8-bit minute counter: synchronous load, saturating increment and decrement.
module al_min_counter
    import al_pkg::*;
(
    input  logic                clk256,
    input  logic                reset,
    input  logic                load,
    input  logic [AL_CNT_W-1:0] load_val,
    input  logic                inc,
    input  logic                dec,
    output logic [AL_CNT_W-1:0] count
);

    logic [AL_CNT_W-1:0] count_q, count_d;

    // Load wins over counting; both directions stick at their end values.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (inc && (count_q != '1)) begin
            count_d = count_q + 8'd1;
        end else if (dec && (count_q != '0)) begin
            count_d = count_q - 8'd1;
        end
    end

    always_ff @(posedge clk256 or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/al_alarm_ctrl.sv
// Alarm sequencer: HHMM match detection and the ring / snooze / off state machine.
module al_alarm_ctrl
    import al_pkg::*;
#(
    parameter int unsigned SNOOZE_MIN       = 9,
    parameter int unsigned RING_TIMEOUT_MIN = 60
) (
    input  logic                 clk256,
    input  logic                 reset,
    input  logic                 one_second,
    input  logic                 one_minute,
    input  logic [AL_HHMM_W-1:0] current_time,
    input  logic [AL_HHMM_W-1:0] alarm_time,
    input  logic                 alarm_enable,
    input  logic                 snooze,
    input  logic                 alarm_off,
    output logic                 sound_alarm,
    output logic                 ringing,
    output logic                 snoozing,
    output logic [AL_CNT_W-1:0]  snooze_left
);

    localparam logic [AL_CNT_W-1:0] SnoozeLoad  = AL_CNT_W'(SNOOZE_MIN);
    localparam logic [AL_CNT_W-1:0] TimeoutLast = AL_CNT_W'(RING_TIMEOUT_MIN - 1);

    al_state_t           state_q, state_d;
    logic                fired_q, fired_d;
    logic                beep_q, beep_d;
    logic                match, timeout, enter_ring;
    logic                ringing_d, snoozing_d, sound_alarm_d;
    logic [AL_CNT_W-1:0] ring_cnt, snooze_cnt;
    logic                snz_load;
    logic [AL_CNT_W-1:0] snz_load_val;

    assign match = (current_time == alarm_time);
    // Timeout fires on the minute pulse that brings ring_cnt up to the limit.
    assign timeout = (state_q == AL_RING) && one_minute && (ring_cnt >= TimeoutLast);

    always_ff @(posedge clk256 or negedge reset) begin
        if (!reset) begin
            state_q     <= AL_IDLE;
            fired_q     <= 1'b0;
            beep_q      <= 1'b0;
            ringing     <= 1'b0;
            snoozing    <= 1'b0;
            sound_alarm <= 1'b0;
        end else begin
            state_q     <= state_d;
            fired_q     <= fired_d;
            beep_q      <= beep_d;
            ringing     <= ringing_d;
            snoozing    <= snoozing_d;
            sound_alarm <= sound_alarm_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            AL_IDLE: begin
                if (alarm_enable && match && !fired_q) state_d = AL_RING;
            end
            AL_RING: begin
                if (alarm_off || !alarm_enable) state_d = AL_IDLE;
                else if (snooze)                state_d = AL_SNOOZE;
                else if (timeout)               state_d = AL_IDLE;
            end
            AL_SNOOZE: begin
                if (alarm_off || !alarm_enable)               state_d = AL_IDLE;
                else if (one_minute && (snooze_cnt == 8'd1)) state_d = AL_RING;
            end
            default: state_d = AL_IDLE;
        endcase
    end

    always_comb begin
        enter_ring    = (state_d == AL_RING) && (state_q != AL_RING);
        // fired only latches on a fresh IDLE trigger and drops as soon as the minute moves on.
        fired_d       = match && (fired_q || (enter_ring && (state_q == AL_IDLE)));
        beep_d        = beep_q;
        if (enter_ring) begin
            beep_d = 1'b1;
        end else if ((state_q == AL_RING) && one_second) begin
            beep_d = ~beep_q;
        end
        ringing_d     = (state_d == AL_RING);
        snoozing_d    = (state_d == AL_SNOOZE);
        sound_alarm_d = ringing_d && beep_d;
        // Snooze count is held at zero outside SNOOZE so it doubles as snooze_left.
        snz_load      = (state_d != AL_SNOOZE) || (state_q != AL_SNOOZE);
        snz_load_val  = (state_d == AL_SNOOZE) ? SnoozeLoad : '0;
    end

    al_min_counter u_ring_cnt (
        .clk256   (clk256),
        .reset    (reset),
        .load     (enter_ring),
        .load_val ('0),
        .inc      (one_minute && (state_q == AL_RING)),
        .dec      (1'b0),
        .count    (ring_cnt)
    );

    al_min_counter u_snooze_cnt (
        .clk256   (clk256),
        .reset    (reset),
        .load     (snz_load),
        .load_val (snz_load_val),
        .inc      (1'b0),
        .dec      (one_minute),
        .count    (snooze_cnt)
    );

    assign snooze_left = snooze_cnt;

endmodule

// File: tb/tb_al_alarm_ctrl.sv
// Self-checking bench for al_alarm_ctrl: directed scenarios plus randomized traffic vs a model.
module tb_al_alarm_ctrl;

    localparam int unsigned SnoozeMin  = 9;
    localparam int unsigned TimeoutMin = 60;

    logic        clk256 = 1'b0;
    logic        reset;
    logic        one_second, one_minute, alarm_enable, snooze, alarm_off;
    logic [15:0] current_time, alarm_time;
    logic        sound_alarm, ringing, snoozing;
    logic [7:0]  snooze_left;

    int n_vec = 0;
    int n_err = 0;

    typedef enum {MIdle, MRing, MSnooze} mode_t;
    mode_t m_mode;
    bit    m_fired, m_beep;
    int    m_ring_minutes, m_snooze_left;

    al_alarm_ctrl #(
        .SNOOZE_MIN       (SnoozeMin),
        .RING_TIMEOUT_MIN (TimeoutMin)
    ) dut (
        .clk256       (clk256),
        .reset        (reset),
        .one_second   (one_second),
        .one_minute   (one_minute),
        .current_time (current_time),
        .alarm_time   (alarm_time),
        .alarm_enable (alarm_enable),
        .snooze       (snooze),
        .alarm_off    (alarm_off),
        .sound_alarm  (sound_alarm),
        .ringing      (ringing),
        .snoozing     (snoozing),
        .snooze_left  (snooze_left)
    );

    always #5 clk256 = ~clk256;

    task automatic model_reset();
        m_mode = MIdle; m_fired = 0; m_beep = 0; m_ring_minutes = 0; m_snooze_left = 0;
    endtask

    task automatic model_start_ring();
        m_mode = MRing; m_ring_minutes = 0; m_beep = 1;
    endtask

    // Behaviour over one clock, from the inputs currently applied.
    task automatic model_step();
        logic match;
        match = (current_time == alarm_time);
        case (m_mode)
            MIdle: if (alarm_enable && match && !m_fired) begin
                model_start_ring();
                m_fired = 1;
            end
            MRing: begin
                if (alarm_off || !alarm_enable) m_mode = MIdle;
                else if (snooze) begin
                    m_mode = MSnooze;
                    m_snooze_left = SnoozeMin;
                end else begin
                    if (one_minute) m_ring_minutes++;
                    if (m_ring_minutes >= TimeoutMin) m_mode = MIdle;
                    else if (one_second) m_beep = !m_beep;
                end
            end
            MSnooze: begin
                if (alarm_off || !alarm_enable) m_mode = MIdle;
                else if (one_minute) begin
                    m_snooze_left--;
                    if (m_snooze_left == 0) model_start_ring();
                end
            end
            default: m_mode = MIdle;
        endcase
        if (!match) m_fired = 0;
    endtask

    task automatic step();
        model_step();
        @(posedge clk256);
        #1;
        one_second = 0; one_minute = 0; snooze = 0; alarm_off = 0;
    endtask

    task automatic test_reset();
        #2;
        n_vec++; if (ringing !== 1'b0) begin n_err++; $display("FAIL reset_ringing got %b want 0", ringing); end
        n_vec++; if (snoozing !== 1'b0) begin n_err++; $display("FAIL reset_snoozing got %b want 0", snoozing); end
        n_vec++; if (sound_alarm !== 1'b0) begin n_err++; $display("FAIL reset_sound got %b want 0", sound_alarm); end
        n_vec++; if (snooze_left !== 8'd0) begin n_err++; $display("FAIL reset_left got %0d want 0", snooze_left); end
        @(posedge clk256); #1;
        reset = 1;
        model_reset();
        for (int i = 0; i < 3; i++) step();
        n_vec++; if (ringing !== 1'b0) begin n_err++; $display("FAIL idle_no_match got %b want 0", ringing); end
    endtask

    task automatic test_ring_beep();
        current_time = 16'h0700; one_minute = 1; step();
        n_vec++; if (ringing !== 1'b1) begin n_err++; $display("FAIL match_ringing got %b want 1", ringing); end
        n_vec++; if (sound_alarm !== 1'b1) begin n_err++; $display("FAIL match_sound got %b want 1", sound_alarm); end
        for (int k = 1; k <= 4; k++) begin
            one_second = 1; step();
            n_vec++;
            if (sound_alarm !== ((k % 2) == 0)) begin
                n_err++; $display("FAIL beep_toggle %0d got %b want %b", k, sound_alarm, (k % 2) == 0);
            end
        end
        step();
        n_vec++; if (sound_alarm !== 1'b1) begin n_err++; $display("FAIL beep_hold got %b want 1", sound_alarm); end
    endtask

    task automatic test_snooze();
        snooze = 1; step();
        n_vec++; if (snoozing !== 1'b1) begin n_err++; $display("FAIL snz_enter got %b want 1", snoozing); end
        n_vec++; if (snooze_left !== 8'(SnoozeMin)) begin n_err++; $display("FAIL snz_load got %0d want %0d", snooze_left, SnoozeMin); end
        n_vec++; if (sound_alarm !== 1'b0) begin n_err++; $display("FAIL snz_quiet got %b want 0", sound_alarm); end
        for (int i = 1; i <= 9; i++) begin
            one_minute = 1;
            snooze = (i == 3);
            step();
            n_vec++;
            if (i < 9) begin
                if (snooze_left !== 8'(9 - i)) begin
                    n_err++; $display("FAIL snz_count %0d got %0d want %0d", i, snooze_left, 9 - i);
                end
            end else if (ringing !== 1'b1 || snooze_left !== 8'd0 || sound_alarm !== 1'b1) begin
                n_err++; $display("FAIL snz_expire got ring=%b left=%0d snd=%b want 1/0/1", ringing, snooze_left, sound_alarm);
            end
        end
    endtask

    task automatic test_off_no_retrigger();
        alarm_off = 1; step();
        n_vec++; if (ringing !== 1'b0) begin n_err++; $display("FAIL off_stop got %b want 0", ringing); end
        for (int i = 0; i < 5; i++) begin one_minute = (i % 2); step(); end
        n_vec++; if (ringing !== 1'b0) begin n_err++; $display("FAIL off_no_retrigger got %b want 0", ringing); end
        current_time = 16'h0659; step();
        current_time = 16'h0700; step();
        n_vec++; if (ringing !== 1'b1) begin n_err++; $display("FAIL off_rearm got %b want 1", ringing); end
    endtask

    task automatic test_timeout();
        for (int i = 1; i <= 60; i++) begin
            one_minute = 1; step();
            if (i == 59) begin
                n_vec++; if (ringing !== 1'b1) begin n_err++; $display("FAIL tmo_early got %b want 1", ringing); end
            end
        end
        n_vec++; if (ringing !== 1'b0 || sound_alarm !== 1'b0) begin
            n_err++; $display("FAIL tmo_stop got ring=%b snd=%b want 0/0", ringing, sound_alarm);
        end
        current_time = 16'h0659; step();
        current_time = 16'h0700; step();
        snooze = 1; alarm_off = 1; step();
        n_vec++; if (ringing !== 1'b0 || snoozing !== 1'b0) begin
            n_err++; $display("FAIL off_beats_snooze got ring=%b snz=%b want 0/0", ringing, snoozing);
        end
    endtask

    task automatic test_enable();
        current_time = 16'h0659; step();
        alarm_enable = 0; current_time = 16'h0700; step(); step();
        n_vec++; if (ringing !== 1'b0) begin n_err++; $display("FAIL disabled_match got %b want 0", ringing); end
        alarm_enable = 1; step();
        n_vec++; if (ringing !== 1'b1) begin n_err++; $display("FAIL enable_late got %b want 1", ringing); end
        snooze = 1; step();
        alarm_enable = 0; step();
        n_vec++; if (snoozing !== 1'b0 || ringing !== 1'b0) begin
            n_err++; $display("FAIL disable_in_snooze got snz=%b ring=%b want 0/0", snoozing, ringing);
        end
        alarm_enable = 1; step();
        n_vec++; if (ringing !== 1'b0) begin n_err++; $display("FAIL fired_holds got %b want 0", ringing); end
    endtask

    task automatic test_reset_mid_snooze();
        current_time = 16'h0659; step();
        current_time = 16'h0700; step();
        snooze = 1; step();
        for (int i = 0; i < 5; i++) begin one_minute = 1; step(); end
        n_vec++; if (snooze_left !== 8'd4) begin n_err++; $display("FAIL pre_reset_left got %0d want 4", snooze_left); end
        reset = 0;
        #2;
        n_vec++; if ({sound_alarm, ringing, snoozing, snooze_left} !== 11'd0) begin
            n_err++; $display("FAIL async_reset got snd=%b ring=%b snz=%b left=%0d want all 0",
                              sound_alarm, ringing, snoozing, snooze_left);
        end
        current_time = 16'h0659;
        reset = 1;
        model_reset();
        for (int i = 0; i < 3; i++) begin one_minute = 1; step(); end
        n_vec++; if (ringing !== 1'b0 || snoozing !== 1'b0) begin
            n_err++; $display("FAIL post_reset_idle got ring=%b snz=%b want 0/0", ringing, snoozing);
        end
    endtask

    task automatic test_random();
        logic       exp_ring, exp_snz, exp_snd;
        logic [7:0] exp_left;
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 19) == 0) begin
                case ($urandom_range(0, 2))
                    0:       current_time = 16'h0659;
                    1:       current_time = 16'h0700;
                    default: current_time = 16'h0701;
                endcase
            end
            if ($urandom_range(0, 49) == 0) alarm_time = ($urandom_range(0, 3) == 0) ? 16'h0659 : 16'h0700;
            if ($urandom_range(0, 149) == 0) alarm_enable = !alarm_enable;
            one_second = ($urandom_range(0, 3) == 0);
            one_minute = ($urandom_range(0, 2) == 0);
            snooze     = ($urandom_range(0, 11) == 0);
            alarm_off  = ($urandom_range(0, 149) == 0);
            step();
            exp_ring = (m_mode == MRing);
            exp_snz  = (m_mode == MSnooze);
            exp_snd  = exp_ring && m_beep;
            exp_left = exp_snz ? 8'(m_snooze_left) : 8'd0;
            n_vec++; if (ringing !== exp_ring) begin n_err++; $display("FAIL rnd_ringing cyc %0d got %b want %b", c, ringing, exp_ring); end
            n_vec++; if (snoozing !== exp_snz) begin n_err++; $display("FAIL rnd_snoozing cyc %0d got %b want %b", c, snoozing, exp_snz); end
            n_vec++; if (sound_alarm !== exp_snd) begin n_err++; $display("FAIL rnd_sound cyc %0d got %b want %b", c, sound_alarm, exp_snd); end
            n_vec++; if (snooze_left !== exp_left) begin n_err++; $display("FAIL rnd_left cyc %0d got %0d want %0d", c, snooze_left, exp_left); end
        end
    endtask

    initial begin
        reset = 0;
        one_second = 0; one_minute = 0; snooze = 0; alarm_off = 0;
        alarm_enable = 1;
        current_time = 16'h0659;
        alarm_time   = 16'h0700;
        model_reset();
        test_reset();
        test_ring_beep();
        test_snooze();
        test_off_no_retrigger();
        test_timeout();
        test_enable();
        test_reset_mid_snooze();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
